// File: rtl/gcn_row_memory_server.sv
// Row-wide weight/feature storage for the GCN core: row-load write port, burst read
// engine and a fixed-latency registered read pipe over the split weight/feature address map.
module gcn_row_memory_server #(
  parameter int unsigned DATA_WIDTH    = 5,
  parameter int unsigned ROW_LEN       = 96,
  parameter int unsigned WEIGHT_DEPTH  = 3,
  parameter int unsigned FEATURE_DEPTH = 6,
  parameter int unsigned ADDRESS_WIDTH = 13,
  parameter int unsigned FEATURE_BASE  = 512,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned BURST_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDRESS_WIDTH-1:0]      wr_address,
  input  logic [ROW_LEN*DATA_WIDTH-1:0] wr_data,
  input  logic                          enable_read,
  input  logic [ADDRESS_WIDTH-1:0]      read_address,
  input  logic [BURST_WIDTH-1:0]        burst_len,
  output logic                          busy,
  output logic                          data_valid,
  output logic [ROW_LEN*DATA_WIDTH-1:0] data_out,
  output logic [ADDRESS_WIDTH-1:0]      data_address,
  output logic                          addr_error
);

  localparam int unsigned RowW  = ROW_LEN * DATA_WIDTH;
  localparam int unsigned WIdxW = (WEIGHT_DEPTH > 1) ? $clog2(WEIGHT_DEPTH) : 1;
  localparam int unsigned FIdxW = (FEATURE_DEPTH > 1) ? $clog2(FEATURE_DEPTH) : 1;

  localparam logic [ADDRESS_WIDTH-1:0] WDepthA = ADDRESS_WIDTH'(WEIGHT_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] FDepthA = ADDRESS_WIDTH'(FEATURE_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] FBaseA  = ADDRESS_WIDTH'(FEATURE_BASE);

  typedef struct packed {
    logic             hit_w;
    logic             hit_f;
    logic [WIdxW-1:0] widx;
    logic [FIdxW-1:0] fidx;
  } dec_t;

  function automatic dec_t decode(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] foff;
    dec_t                     d;
    foff   = addr - FBaseA;
    d.hit_w = (addr < WDepthA);
    d.hit_f = (addr >= FBaseA) && (foff < FDepthA);
    d.widx  = addr[WIdxW-1:0];
    d.fidx  = foff[FIdxW-1:0];
    return d;
  endfunction

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  logic [RowW-1:0] weight_mem  [WEIGHT_DEPTH];
  logic [RowW-1:0] feature_mem [FEATURE_DEPTH];

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BURST_WIDTH-1:0]   remain_q, remain_d;
  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_addr;
  dec_t                     wr_dec, rd_dec;
  logic [RowW-1:0]          rd_row;
  logic                     rd_err;

  logic                     pipe_valid_q [READ_LATENCY];
  logic [ADDRESS_WIDTH-1:0] pipe_addr_q  [READ_LATENCY];
  logic [RowW-1:0]          pipe_data_q  [READ_LATENCY];
  logic                     pipe_err_q   [READ_LATENCY];

  assign wr_dec = decode(wr_address);

  // Storage is deliberately not reset; reset only suppresses a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      if (wr_dec.hit_w) begin
        weight_mem[wr_dec.widx] <= wr_data;
      end else if (wr_dec.hit_f) begin
        feature_mem[wr_dec.fidx] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    issue_valid = 1'b0;
    issue_addr  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (enable_read) begin
          issue_valid = 1'b1;
          issue_addr  = read_address;
          // burst_len of 0 or 1 is a single read and never leaves idle.
          if (burst_len > BURST_WIDTH'(1)) begin
            state_d  = StBurst;
            addr_d   = read_address + ADDRESS_WIDTH'(1);
            remain_d = burst_len - BURST_WIDTH'(1);
          end
        end
      end
      StBurst: begin
        issue_valid = 1'b1;
        issue_addr  = addr_q;
        addr_d      = addr_q + ADDRESS_WIDTH'(1);
        remain_d    = remain_q - BURST_WIDTH'(1);
        if (remain_q == BURST_WIDTH'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Array is sampled in the issue cycle, so a same-cycle write is not yet visible.
  always_comb begin
    rd_dec = decode(issue_addr);
    rd_row = '0;
    rd_err = 1'b1;
    if (rd_dec.hit_w) begin
      rd_row = weight_mem[rd_dec.widx];
      rd_err = 1'b0;
    end else if (rd_dec.hit_f) begin
      rd_row = feature_mem[rd_dec.fidx];
      rd_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_addr_q[i]  <= '0;
        pipe_data_q[i]  <= '0;
        pipe_err_q[i]   <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      pipe_valid_q[0] <= issue_valid;
      pipe_addr_q[0]  <= issue_valid ? issue_addr : '0;
      pipe_data_q[0]  <= issue_valid ? rd_row : '0;
      pipe_err_q[0]   <= issue_valid & rd_err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_addr_q[i]  <= pipe_addr_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
      end
    end
  end

  assign busy         = (state_q == StBurst);
  assign data_valid   = pipe_valid_q[READ_LATENCY-1];
  assign data_address = pipe_addr_q[READ_LATENCY-1];
  assign data_out     = pipe_data_q[READ_LATENCY-1];
  assign addr_error   = pipe_err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_gcn_row_memory_server.sv
// Scoreboard bench: instance a uses default parameters, instance b uses READ_LATENCY=3
// and ADDRESS_WIDTH=12 for the latency and address-wrap cases.
module tb_gcn_row_memory_server;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         a_wr_en = 1'b0, a_en = 1'b0;
  logic [12:0]  a_wr_addr = '0, a_raddr = '0;
  logic [479:0] a_wr_data = '0;
  logic [3:0]   a_blen = '0;
  logic         a_busy, a_dv, a_err;
  logic [479:0] a_dout;
  logic [12:0]  a_daddr;

  logic         b_wr_en = 1'b0, b_en = 1'b0;
  logic [11:0]  b_wr_addr = '0, b_raddr = '0;
  logic [479:0] b_wr_data = '0;
  logic [3:0]   b_blen = '0;
  logic         b_busy, b_dv, b_err;
  logic [479:0] b_dout;
  logic [11:0]  b_daddr;

  gcn_row_memory_server dut_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_address(a_wr_addr), .wr_data(a_wr_data),
    .enable_read(a_en), .read_address(a_raddr), .burst_len(a_blen), .busy(a_busy),
    .data_valid(a_dv), .data_out(a_dout), .data_address(a_daddr), .addr_error(a_err)
  );

  gcn_row_memory_server #(.READ_LATENCY(3), .ADDRESS_WIDTH(12)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_address(b_wr_addr), .wr_data(b_wr_data),
    .enable_read(b_en), .read_address(b_raddr), .burst_len(b_blen), .busy(b_busy),
    .data_valid(b_dv), .data_out(b_dout), .data_address(b_daddr), .addr_error(b_err)
  );

  typedef struct {
    int           due;
    int           addr;
    logic [479:0] data;
    logic         err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [479:0] wmod [2][3];
  logic [479:0] fmod [2][6];

  function automatic logic is_mapped(input int a);
    return (a < 3) || (a >= 512 && a < 518);
  endfunction

  function automatic logic [479:0] mrow(input int d, input int a);
    if (a < 3) return wmod[d][a];
    if (a >= 512 && a < 518) return fmod[d][a-512];
    return '0;
  endfunction

  // Element i = (i*mul + off) mod 32.
  function automatic logic [479:0] ramp(input int off, input int mul);
    logic [479:0] r;
    for (int i = 0; i < 96; i++) r[i*5 +: 5] = 5'((i * mul + off) % 32);
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic mon(input int d, input logic dv, input logic [479:0] dout, input int daddr,
                     input logic err);
    exp_t e;
    int   n;
    n = (d == 0) ? qa.size() : qb.size();
    checks++;
    if (dv) begin
      if (n == 0) begin
        errors++;
        $display("FAIL beat%0d_unexpected: got beat addr %0d, required no beat (cycle %0d)",
                 d, daddr, cyc);
      end else begin
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (e.due != cyc || e.addr != daddr || e.err != err || e.data !== dout) begin
          errors++;
          $display("FAIL beat%0d: got cyc %0d addr %0d err %0b data %h, required cyc %0d addr %0d err %0b data %h",
                   d, cyc, daddr, err, dout, e.due, e.addr, e.err, e.data);
        end
      end
    end else begin
      if (dout !== '0 || daddr != 0 || err !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero%0d: got addr %0d err %0b, required all zero (cycle %0d)",
                 d, daddr, err, cyc);
      end
      if (n > 0) begin
        e = (d == 0) ? qa[0] : qb[0];
        if (e.due <= cyc) begin
          errors++;
          $display("FAIL beat%0d_missing: got no beat at cycle %0d, required addr %0d", d, cyc,
                   e.addr);
          if (d == 0) void'(qa.pop_front());
          else void'(qb.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_dv, a_dout, int'(a_daddr), a_err);
    mon(1, b_dv, b_dout, int'(b_daddr), b_err);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wrow(input int d, input int addr, input logic [479:0] row);
    if (d == 0) begin
      a_wr_en = 1'b1; a_wr_addr = 13'(addr); a_wr_data = row;
    end else begin
      b_wr_en = 1'b1; b_wr_addr = 12'(addr); b_wr_data = row;
    end
    @(negedge clk);
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    if (addr < 3) wmod[d][addr] = row;
    else if (is_mapped(addr)) fmod[d][addr-512] = row;
  endtask

  // Issues a request and queues the first nexp beats it should produce.
  task automatic issue(input int d, input int addr, input int blen, input int nexp);
    int   n, lat, mask;
    exp_t e;
    n    = (blen == 0) ? 1 : blen;
    lat  = (d == 0) ? 1 : 3;
    mask = (d == 0) ? 'h1fff : 'hfff;
    for (int i = 0; i < n && i < nexp; i++) begin
      e.due  = cyc + i + lat;
      e.addr = (addr + i) & mask;
      e.data = mrow(d, e.addr);
      e.err  = !is_mapped(e.addr);
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    if (d == 0) begin
      a_en = 1'b1; a_raddr = 13'(addr); a_blen = 4'(blen);
    end else begin
      b_en = 1'b1; b_raddr = 12'(addr); b_blen = 4'(blen);
    end
    @(negedge clk);
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("reset_busy_a", int'(a_busy), 0);
    chk("reset_valid_a", int'(a_dv), 0);
    chk("reset_busy_b", int'(b_busy), 0);
    reset = 1'b0;
    tick(1);

    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) wrow(d, r, (r == 2) ? ramp(7, 0) : ramp(r + 1, 3));
      for (int f = 0; f < 6; f++) wrow(d, 512 + f, (f == 0) ? ramp(0, 1) : ramp(f * 5, f + 1));
    end
    tick(2);

    // Single reads, latency 1.
    issue(0, 2, 1, 1);
    chk("single_no_busy", int'(a_busy), 0);
    tick(2);
    issue(0, 512, 1, 1);
    tick(2);

    // Burst of 3 from 0; request during busy must be ignored.
    issue(0, 0, 3, 3);
    chk("burst_busy_1", int'(a_busy), 1);
    a_en = 1'b1; a_raddr = 13'd5; a_blen = 4'd1;
    tick(1);
    a_en = 1'b0;
    chk("burst_busy_2", int'(a_busy), 1);
    tick(1);
    chk("burst_busy_end", int'(a_busy), 0);
    tick(3);

    // Burst crossing out of the weight region.
    issue(0, 1, 4, 4);
    tick(6);

    // Read-before-write on the same row, then the new data.
    a_wr_en = 1'b1; a_wr_addr = 13'd513; a_wr_data = ramp(31, 0);
    issue(0, 513, 1, 1);
    a_wr_en = 1'b0;
    fmod[0][1] = ramp(31, 0);
    issue(0, 513, 1, 1);
    tick(3);

    // Reset on the second burst cycle; a write alongside reset is dropped.
    issue(0, 0, 5, 1);
    reset = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 13'd0; a_wr_data = '0;
    tick(1);
    reset = 1'b0;
    a_wr_en = 1'b0;
    chk("midreset_busy", int'(a_busy), 0);
    chk("midreset_valid", int'(a_dv), 0);
    tick(4);
    issue(0, 0, 1, 1);
    issue(0, 2, 1, 1);
    issue(0, 512, 1, 1);
    tick(3);

    // Latency 3, burst_len 0 is one beat.
    issue(1, 515, 0, 1);
    chk("len0_no_busy", int'(b_busy), 0);
    tick(6);

    // Address wrap at 12 bits.
    issue(1, 'hfff, 2, 2);
    tick(6);

    chk("drained_a", qa.size(), 0);
    chk("drained_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcn_row_memory_server.md
Name: gcn_row_memory_server

Overview:
Synthesizable, parametrised row-wide storage for the GCN accelerator's weight and feature matrices. It presents the same split address map the core already uses: weight rows from address 0, feature rows from FEATURE_BASE. It adds three things over a plain combinational lookup: a row-load write port, a configurable registered read latency, and an auto-incrementing burst read engine. The block sits between the host/loader and the GCN core's read_address/data_in interface.

Parameters:
DATA_WIDTH, 5, bits per matrix element (shared by weight and feature)
ROW_LEN, 96, elements per stored row
WEIGHT_DEPTH, 3, number of weight rows
FEATURE_DEPTH, 6, number of feature rows
ADDRESS_WIDTH, 13, read/write address width
FEATURE_BASE, 512, first feature-row address; must be >= WEIGHT_DEPTH
READ_LATENCY, 1, cycles from issue to data_valid; legal range 1..4
BURST_WIDTH, 4, width of burst_len

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wr_en  in  1  load one row this cycle
wr_address  in  ADDRESS_WIDTH  row address to load (same map as reads)
wr_data  in  ROW_LEN*DATA_WIDTH  row data; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
enable_read  in  1  read/burst request
read_address  in  ADDRESS_WIDTH  start row address
burst_len  in  BURST_WIDTH  rows to read; 0 is treated as 1
busy  out  1  burst in progress; new requests are ignored
data_valid  out  1  data_out/data_address are valid this cycle
data_out  out  ROW_LEN*DATA_WIDTH  returned row, same packing as wr_data
data_address  out  ADDRESS_WIDTH  address that produced data_out
addr_error  out  1  qualifies data_valid: address decoded to no row

Behaviour:
- Decode, applied identically to reads and writes:
  - addr < WEIGHT_DEPTH -> weight row addr.
  - FEATURE_BASE <= addr < FEATURE_BASE+FEATURE_DEPTH -> feature row (addr-FEATURE_BASE).
  - Anything else is unmapped.
- Storage: arrays are not reset; contents persist across reset. Writes to unmapped addresses are ignored silently.
- FSM has two states, IDLE and BURST.
  - IDLE: enable_read=1 accepts the request. In that same cycle, address A=read_address is issued. If N=max(burst_len,1) > 1, the FSM latches A+1 and remaining=N-1 and goes to BURST; otherwise it stays in IDLE.
  - BURST: issues one address per cycle and increments it modulo 2^ADDRESS_WIDTH. It returns to IDLE in the cycle the last address issues. enable_read is ignored while in BURST.
  - busy = (state==BURST). It is registered, so busy rises the cycle after accept.
  - A request presented in the cycle after the last issue is accepted normally (back-to-back bursts).
- Read pipeline:
  - Every issued address enters a READ_LATENCY-stage valid/address/data shift pipe. Array read happens at stage 1.
  - Issue in cycle t -> data_valid=1 in cycle t+READ_LATENCY.
  - One row per cycle sustained; no backpressure.
- Unmapped reads still produce a data_valid beat, with data_out=0, data_address=the address and addr_error=1. The burst continues.
- Bursts may cross region boundaries; each address is decoded independently.
- Same-cycle read and write to the same row: the read returns the old data (read-before-write). A write lands in the cycle it is presented and is visible to reads issued from the next cycle on.
- When data_valid=0: data_out, data_address and addr_error are all 0.
- Reset values: busy=0, data_valid=0, data_out=0, data_address=0, addr_error=0, state=IDLE, and all pipe valids cleared.
- Reset mid-burst aborts the burst and flushes the pipe. No data_valid in the cycle after reset is sampled. Reset dominates a same-cycle enable_read or wr_en (the write is dropped).

Test Plan:
- Load weight row 2 with all elements 5'd7 and feature row 0 (addr 512) with element i = i%32. Single reads at 2, then 512, with READ_LATENCY=1 -> data_valid exactly 1 cycle after each issue, with matching data_out and data_address.
- Burst read_address=0, burst_len=3 -> three consecutive valid beats for addresses 0,1,2; busy high for 2 cycles; enable_read pulsed during busy has no effect.
- Burst read_address=1, burst_len=4 with WEIGHT_DEPTH=3 -> beats for 1,2 have addr_error=0; beats for 3,4 have addr_error=1 and data_out=0.
- READ_LATENCY=3, burst_len=0 at 515 -> exactly one beat, 3 cycles after issue, carrying feature row 3.
- Write row 513 := 5'd31 in all elements in the same cycle a read of 513 issues -> that beat returns the old data; a read the next cycle returns all 5'd31.
- Assert reset on the 2nd cycle of a 5-row burst -> no further data_valid, busy=0 and outputs 0. Previously loaded rows still read back correctly afterwards. A burst at 0xFFF, len 2 (ADDRESS_WIDTH=12) wraps to address 0.
